// File: rtl/trigger_input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : trigger_input_conditioner                                       |
// | Synchronizes, polarity-corrects, glitch-filters and holds off an external  |
// | trigger pin; emits a one-cycle pulse per accepted trigger.                 |
// | Option   : define TRIG_IN_CNT_EN to build the accept/drop counters.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module trigger_input_conditioner #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_trig_in_enable,
  input  logic        reg_trig_in_polar,
  input  logic [31:0] reg_trig_in_filter,
  input  logic [31:0] reg_trig_in_holdoff,
  input  logic        reg_trig_in_cnt_clr,
  input  logic        trigger_pin,
  output logic        trigger_out,
  output logic        trigger_level,
  output logic [31:0] trig_accept_cnt,
  output logic [31:0] trig_drop_cnt
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_HOLDOFF = 1'b1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic [31:0]            w_filt_lim;
  logic [31:0]            r_filt_cnt;
  logic                   r_level;
  logic                   r_level_d;
  logic                   w_rise;
  logic [0:0]             r_state;
  logic [31:0]            r_hold_cnt;
  logic                   r_trig_out;
  logic                   w_accept;
  logic                   w_drop;

  // Disabled or reset: flops hold the inactive pin level so re-enable sees a clean edge.
  always_ff @(posedge clk) begin
    if (rst || !reg_trig_in_enable) begin
      r_sync <= {SYNC_STAGES{reg_trig_in_polar}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], trigger_pin};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1] ^ reg_trig_in_polar;

  // Toggle when the count would reach F = max(filter, 1), i.e. count >= F-1.
  assign w_filt_lim = (reg_trig_in_filter == 32'd0) ? 32'd0 : (reg_trig_in_filter - 32'd1);

  always_ff @(posedge clk) begin
    if (rst || !reg_trig_in_enable) begin
      r_filt_cnt <= 32'd0;
      r_level    <= 1'b0;
      r_level_d  <= 1'b0;
    end else begin
      r_level_d <= r_level;
      if (w_s == r_level) begin
        r_filt_cnt <= 32'd0;
      end else if (r_filt_cnt >= w_filt_lim) begin
        r_filt_cnt <= 32'd0;
        r_level    <= ~r_level;
      end else begin
        r_filt_cnt <= r_filt_cnt + 32'd1;
      end
    end
  end

  assign w_rise   = r_level & ~r_level_d;
  assign w_accept = reg_trig_in_enable && (r_state == ST_IDLE)    && w_rise;
  assign w_drop   = reg_trig_in_enable && (r_state == ST_HOLDOFF) && w_rise;

  always_ff @(posedge clk) begin
    if (rst || !reg_trig_in_enable) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= 32'd0;
      r_trig_out <= 1'b0;
    end else begin
      r_trig_out <= w_accept;
      case (r_state)
        ST_IDLE: begin
          if (w_rise && (reg_trig_in_holdoff != 32'd0)) begin
            r_hold_cnt <= reg_trig_in_holdoff;
            r_state    <= ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          r_hold_cnt <= r_hold_cnt - 32'd1;
          if (r_hold_cnt <= 32'd1) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_hold_cnt <= 32'd0;
        end
      endcase
    end
  end

  assign trigger_out   = r_trig_out;
  assign trigger_level = r_level;

`ifdef TRIG_IN_CNT_EN
  logic [31:0] r_accept_cnt;
  logic [31:0] r_drop_cnt;

  // Clear wins over a same-cycle increment; both counters saturate.
  always_ff @(posedge clk) begin
    if (rst || reg_trig_in_cnt_clr) begin
      r_accept_cnt <= 32'd0;
      r_drop_cnt   <= 32'd0;
    end else begin
      if (w_accept && (r_accept_cnt != 32'hFFFF_FFFF)) begin
        r_accept_cnt <= r_accept_cnt + 32'd1;
      end
      if (w_drop && (r_drop_cnt != 32'hFFFF_FFFF)) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
      end
    end
  end

  assign trig_accept_cnt = r_accept_cnt;
  assign trig_drop_cnt   = r_drop_cnt;
`else
  logic w_unused_cnt;
  assign w_unused_cnt    = ^{reg_trig_in_cnt_clr, w_accept, w_drop};
  assign trig_accept_cnt = 32'd0;
  assign trig_drop_cnt   = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_trigger_input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_trigger_input_conditioner                                    |
// | Directed self-checking bench for trigger_input_conditioner.                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_trigger_input_conditioner;

`ifdef TRIG_IN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        polar;
  logic [31:0] filt;
  logic [31:0] hold;
  logic        clr;
  logic        pin;
  logic        tout;
  logic        tlvl;
  logic [31:0] acc;
  logic [31:0] drp;

  int n_tests = 0;
  int n_fail  = 0;

  trigger_input_conditioner #(.SYNC_STAGES(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .reg_trig_in_enable  (en),
    .reg_trig_in_polar   (polar),
    .reg_trig_in_filter  (filt),
    .reg_trig_in_holdoff (hold),
    .reg_trig_in_cnt_clr (clr),
    .trigger_pin         (pin),
    .trigger_out         (tout),
    .trigger_level       (tlvl),
    .trig_accept_cnt     (acc),
    .trig_drop_cnt       (drp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    pin = polar;
    clr = 1'b0;
    en  = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; polar = 1'b0; filt = 32'd1; hold = 32'd0; clr = 1'b0;
    rst = 1'b1; pin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pin = ~pin;
      step();
      n_tests++;
      if ({tout, tlvl, acc, drp} !== 66'd0) begin
        n_fail++;
        $display("FAIL reset_during cyc %0d: out=%b lvl=%b acc=%0d drop=%0d, want all 0", i, tout, tlvl, acc, drp);
      end
    end
    rst = 1'b0; pin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if ({tout, tlvl, acc, drp} !== 66'd0) begin
        n_fail++;
        $display("FAIL reset_after cyc %0d: out=%b lvl=%b acc=%0d drop=%0d, want all 0", i, tout, tlvl, acc, drp);
      end
    end
  endtask

  task automatic test_nominal();
    int first_lvl;
    int first_pulse;
    int npulse;
    first_lvl = -1; first_pulse = -1; npulse = 0;
    polar = 1'b0; filt = 32'd4; hold = 32'd0;
    do_reset();
    pin = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tlvl && first_lvl < 0) first_lvl = i;
      if (tout) begin
        npulse++;
        if (first_pulse < 0) first_pulse = i;
      end
      if (i == 5 || i == 6) begin
        n_tests++;
        if (acc !== exp_cnt(i - 5)) begin
          n_fail++;
          $display("FAIL nominal_acc_edge%0d: got %0d want %0d", i, acc, exp_cnt(i - 5));
        end
      end
      if (i == 9) pin = 1'b0;
    end
    n_tests++;
    if (first_lvl != 5) begin n_fail++; $display("FAIL nominal_level_edge: got %0d want 5", first_lvl); end
    n_tests++;
    if (first_pulse != 6 || npulse != 1) begin
      n_fail++;
      $display("FAIL nominal_pulse: got edge %0d count %0d want edge 6 count 1", first_pulse, npulse);
    end
    n_tests++;
    if (tlvl !== 1'b0 || drp !== 32'd0) begin
      n_fail++;
      $display("FAIL nominal_end: got lvl=%b drop=%0d want lvl=0 drop=0", tlvl, drp);
    end
  endtask

  task automatic test_glitch();
    int npulse;
    int lvl_seen;
    npulse = 0; lvl_seen = 0;
    polar = 1'b0; filt = 32'd4; hold = 32'd0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      pin = (i < 30) && ((i % 6) < 3);
      step();
      if (tout) npulse++;
      if (tlvl) lvl_seen++;
    end
    n_tests++;
    if (npulse != 0 || lvl_seen != 0) begin
      n_fail++;
      $display("FAIL glitch: got pulses=%0d level_cycles=%0d want 0 0", npulse, lvl_seen);
    end
    n_tests++;
    if (acc !== 32'd0 || drp !== 32'd0) begin
      n_fail++;
      $display("FAIL glitch_counts: got acc=%0d drop=%0d want 0 0", acc, drp);
    end
  endtask

  task automatic test_holdoff();
    int npulse;
    int edges[4];
    npulse = 0;
    polar = 1'b0; filt = 32'd1; hold = 32'd100;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      pin = (i < 4) || (i >= 50 && i < 54) || (i >= 150 && i < 154);
      step();
      if (tout) begin
        if (npulse < 4) edges[npulse] = i;
        npulse++;
      end
    end
    n_tests++;
    if (npulse != 2 || edges[0] != 3 || edges[1] != 153) begin
      n_fail++;
      $display("FAIL holdoff_pulses: got count %0d first %0d second %0d want 2 3 153",
               npulse, edges[0], edges[1]);
    end
    n_tests++;
    if (acc !== exp_cnt(2) || drp !== exp_cnt(1)) begin
      n_fail++;
      $display("FAIL holdoff_counts: got acc=%0d drop=%0d want %0d %0d", acc, drp, exp_cnt(2), exp_cnt(1));
    end
  endtask

  task automatic test_back_to_back();
    int npulse;
    int edges[8];
    npulse = 0;
    polar = 1'b0; filt = 32'd2; hold = 32'd0;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      pin = (i < 16) && ((i % 4) < 2);
      step();
      if (tout) begin
        if (npulse < 8) edges[npulse] = i;
        npulse++;
      end
    end
    n_tests++;
    if (npulse != 4 || edges[0] != 4 || edges[1] != 8 || edges[2] != 12 || edges[3] != 16) begin
      n_fail++;
      $display("FAIL back_to_back: got count %0d edges %0d %0d %0d %0d want 4 at 4 8 12 16",
               npulse, edges[0], edges[1], edges[2], edges[3]);
    end
    n_tests++;
    if (acc !== exp_cnt(4)) begin
      n_fail++;
      $display("FAIL back_to_back_acc: got %0d want %0d", acc, exp_cnt(4));
    end
  endtask

  task automatic test_polarity();
    int npulse;
    int first_pulse;
    npulse = 0; first_pulse = -1;
    polar = 1'b1; filt = 32'd2; hold = 32'd0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      if (tout || tlvl) npulse++;
    end
    n_tests++;
    if (npulse != 0) begin n_fail++; $display("FAIL polarity_idle: got %0d active cycles want 0", npulse); end
    npulse = 0;
    pin = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (tout) begin
        npulse++;
        if (first_pulse < 0) first_pulse = i;
      end
      if (i == 7) pin = 1'b1;
    end
    n_tests++;
    if (npulse != 1 || first_pulse != 4) begin
      n_fail++;
      $display("FAIL polarity_pulse: got count %0d edge %0d want 1 at 4", npulse, first_pulse);
    end
  endtask

  task automatic test_disable();
    int npulse;
    int first_pulse;
    npulse = 0; first_pulse = -1;
    polar = 1'b0; filt = 32'd1; hold = 32'd100;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      pin = (i < 4);
      step();
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (tlvl !== 1'b0 || tout !== 1'b0 || acc !== exp_cnt(1)) begin
        n_fail++;
        $display("FAIL disabled cyc %0d: got lvl=%b out=%b acc=%0d want 0 0 %0d", i, tlvl, tout, acc, exp_cnt(1));
      end
    end
    en = 1'b1;
    step(); step(); step();
    for (int i = 0; i < 10; i++) begin
      pin = (i < 4);
      step();
      if (tout) begin
        npulse++;
        if (first_pulse < 0) first_pulse = i;
      end
    end
    n_tests++;
    if (npulse != 1 || first_pulse != 3) begin
      n_fail++;
      $display("FAIL reenable_pulse: got count %0d edge %0d want 1 at 3", npulse, first_pulse);
    end
    n_tests++;
    if (acc !== exp_cnt(2) || drp !== 32'd0) begin
      n_fail++;
      $display("FAIL reenable_counts: got acc=%0d drop=%0d want %0d 0", acc, drp, exp_cnt(2));
    end
  endtask

  task automatic test_clear();
    polar = 1'b0; filt = 32'd1; hold = 32'd0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pin = (i < 4);
      step();
    end
    n_tests++;
    if (acc !== exp_cnt(1)) begin n_fail++; $display("FAIL clear_pre: got acc=%0d want %0d", acc, exp_cnt(1)); end
    for (int i = 0; i < 10; i++) begin
      pin = (i < 4);
      clr = (i == 3);
      step();
      if (i == 3) begin
        n_tests++;
        if (tout !== 1'b1 || acc !== 32'd0) begin
          n_fail++;
          $display("FAIL clear_same_cycle: got out=%b acc=%0d want 1 0", tout, acc);
        end
      end
    end
    clr = 1'b0;
    n_tests++;
    if (acc !== 32'd0 || drp !== 32'd0) begin
      n_fail++;
      $display("FAIL clear_after: got acc=%0d drop=%0d want 0 0", acc, drp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; polar = 1'b0; filt = 32'd1; hold = 32'd0; clr = 1'b0; pin = 1'b0;
    test_reset();
    test_nominal();
    test_glitch();
    test_holdoff();
    test_back_to_back();
    test_polarity();
    test_disable();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
